// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: icodes, fetch states and byte-layout helpers.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {FETCH, DELIVER, HALTED} state_t;

    function automatic logic has_regs(input logic [3:0] ic);
        case (ic)
            RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ: has_regs = 1'b1;
            default:                                         has_regs = 1'b0;
        endcase
    endfunction

    // Byte index of the first valC byte; 0 means the instruction has no valC.
    function automatic logic [3:0] valc_offset(input logic [3:0] ic);
        case (ic)
            IRMOVQ, RMMOVQ, MRMOVQ: valc_offset = 4'd2;
            JXX, CALL:              valc_offset = 4'd1;
            default:                valc_offset = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/inst_length_lut.sv
// Combinational icode -> instruction length table with validity flag.
module inst_length_lut
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] length,
    output logic       valid
);

    always_comb begin
        valid = 1'b1;
        case (icode)
            HALT, NOP, RET:         length = 4'd1;
            RRMOVQ, OPQ, PUSHQ, POPQ: length = 4'd2;
            IRMOVQ, RMMOVQ, MRMOVQ: length = 4'd10;
            JXX, CALL:              length = 4'd9;
            default: begin
                length = 4'd0;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch: byte-serial memory reads, instruction assembly, PC update.
// Optional FETCH_STATS_EN adds saturating delivered-instruction and stall counters.
module fetch_sequencer
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        halted,
    output logic        error
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_insts,
    output logic [31:0] stat_stalls
`endif
);

    state_t      state;
    logic [3:0]  byte_idx;
    logic        pend;
    logic [63:0] pend_pc;

    logic [3:0]  lut_icode, cur_len, voff, vdiff;
    logic        len_valid, mem_hs, mem_stall;

    // Byte 0 is sized straight off the bus; later bytes use the captured icode.
    assign lut_icode = (byte_idx == 4'd0) ? mem_data[7:4] : icode;
    assign voff      = valc_offset(icode);
    assign vdiff     = byte_idx - voff;
    assign mem_addr  = pc + {60'd0, byte_idx};
    assign mem_hs    = mem_req && mem_ready;
    assign mem_stall = mem_req && !mem_ready;

    inst_length_lut u_len (
        .icode  (lut_icode),
        .length (cur_len),
        .valid  (len_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            byte_idx   <= 4'd0;
            pend       <= 1'b0;
            pend_pc    <= 64'd0;
            mem_req    <= 1'b0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            error      <= 1'b0;
            icode      <= 4'h0;
            ifun       <= 4'h0;
            rA         <= REG_NONE;
            rB         <= REG_NONE;
            valC       <= 64'd0;
            valP       <= 64'd0;
        end else if (redirect_valid && !(state == FETCH && mem_stall)) begin
            state      <= FETCH;
            pc         <= redirect_pc;
            byte_idx   <= 4'd0;
            pend       <= 1'b0;
            mem_req    <= 1'b1;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        // Memory owes us a byte; remember the target until it arrives.
                        pend    <= 1'b1;
                        pend_pc <= redirect_pc;
                    end else if (mem_hs) begin
                        if (pend) begin
                            pend     <= 1'b0;
                            pc       <= pend_pc;
                            byte_idx <= 4'd0;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            if (byte_idx == 4'd0) begin
                                icode <= mem_data[7:4];
                                ifun  <= mem_data[3:0];
                                rA    <= REG_NONE;
                                rB    <= REG_NONE;
                                valC  <= 64'd0;
                            end
                            if (byte_idx == 4'd0 && !len_valid) begin
                                error   <= 1'b1;
                                halted  <= 1'b1;
                                mem_req <= 1'b0;
                                state   <= HALTED;
                            end else begin
                                if (byte_idx == 4'd1 && has_regs(icode))
                                    {rA, rB} <= mem_data;
                                if (voff != 4'd0 && byte_idx >= voff)
                                    valC[{vdiff[2:0], 3'b000} +: 8] <= mem_data;
                                if (byte_idx == cur_len - 4'd1) begin
                                    state      <= DELIVER;
                                    mem_req    <= 1'b0;
                                    inst_valid <= 1'b1;
                                    valP       <= pc + {60'd0, cur_len};
                                end
                            end
                        end
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        pc         <= valP;
                        byte_idx   <= 4'd0;
                        if (icode == HALT) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            mem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    mem_req    <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_insts  <= 32'd0;
            stat_stalls <= 32'd0;
        end else begin
            if (inst_valid && inst_ready && stat_insts != 32'hFFFF_FFFF)
                stat_insts <= stat_insts + 32'd1;
            if ((mem_stall || (inst_valid && !inst_ready)) && stat_stalls != 32'hFFFF_FFFF)
                stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte-wide memory model and hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_ready = 1'b1;
    logic [63:0] mem_addr;
    logic [7:0]  mem_data;
    logic        inst_valid, inst_ready = 1'b0;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        halted, error;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_insts, stat_stalls;
`endif

    logic [7:0] mem [256];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    assign mem_data = mem[mem_addr[7:0]];

    fetch_sequencer #(.RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .icode          (icode),
        .ifun           (ifun),
        .rA             (rA),
        .rB             (rB),
        .valC           (valC),
        .valP           (valP),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .error          (error)
`ifdef FETCH_STATS_EN
        ,
        .stat_insts     (stat_insts),
        .stat_stalls    (stat_stalls)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!inst_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!inst_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic accept();
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int n, k;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        // 0x00: irmovq $10,%rbx ; 0x0A: halt
        mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
        // 0x0B..0x1E: twenty nops, 0x1F: halt
        for (int i = 8'h0B; i <= 8'h1E; i++) mem[i] = 8'h10;
        // 0x40: nop ; 0x41: halt
        mem[8'h40] = 8'h10;
        // 0x60: rmmovq %rcx,8(%rdx) style, valC = 0x0102030405060708
        mem[8'h60] = 8'h40; mem[8'h61] = 8'h12;
        for (int i = 0; i < 8; i++) mem[8'h62 + i] = 8'(8 - i);
        // 0x80: jmp 0x40
        mem[8'h80] = 8'h70; mem[8'h81] = 8'h40;
        // 0xA0: subq %rdx,%rbx ; 0xA2: halt
        mem[8'hA0] = 8'h61; mem[8'hA1] = 8'h23;
        mem[8'hC0] = 8'hC0;
        // 0xE0: mrmovq
        mem[8'hE0] = 8'h50; mem[8'hE1] = 8'h12;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        check("rst_pc", pc, 64'h0);
        check("rst_icode", icode, 0);
        check("rst_rA", rA, 4'hF);
        check("rst_rB", rB, 4'hF);
        check("rst_valC", valC, 0);

        // irmovq then halt, straight-line
        rst = 1'b0;
        n = 0; k = 0;
        while (!inst_valid && k < 50) begin
            if (mem_req && mem_ready) n++;
            @(negedge clk);
            k++;
        end
        check("irm_handshakes", 64'(n), 10);
        check("irm_icode", icode, 4'h3);
        check("irm_rA", rA, 4'hF);
        check("irm_rB", rB, 4'h3);
        check("irm_valC", valC, 64'd10);
        check("irm_valP", valP, 64'd10);
        check("irm_pc", pc, 64'd0);
        accept();
        check("after_irm_pc", pc, 64'd10);
        wait_valid("halt1");
        check("halt1_icode", icode, 4'h0);
        check("halt1_pc", pc, 64'd10);
        check("halt1_valP", valP, 64'd11);
        accept();
        check("halt1_halted", halted, 1);
        check("halt1_mem_req", mem_req, 0);

        // jmp with decode backpressure, redirect coincident with accept
        redirect(64'h80);
        check("hlt_exit_halted", halted, 0);
        check("jmp_addr0", mem_addr, 64'h80);
        wait_valid("jmp");
        for (int i = 0; i < 5; i++) begin
            check("jmp_hold_valid", inst_valid, 1);
            check("jmp_hold_icode", icode, 4'h7);
            check("jmp_hold_rA", rA, 4'hF);
            check("jmp_hold_valC", valC, 64'h40);
            check("jmp_hold_valP", valP, 64'h89);
            check("jmp_hold_pc", pc, 64'h80);
            @(negedge clk);
        end
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        @(negedge clk);
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("jmp_redir_pc", pc, 64'h40);
        check("jmp_redir_addr", mem_addr, 64'h40);
        check("jmp_redir_valid", inst_valid, 0);
        check("jmp_redir_req", mem_req, 1);
        wait_valid("nop");
        check("nop_icode", icode, 4'h1);
        check("nop_valP", valP, 64'h41);
        accept();
        wait_valid("halt2");
        accept();
        check("halt2_halted", halted, 1);

        // Redirect while a byte is stalled at byte_idx 3 of rmmovq
        redirect(64'h60);
        k = 0;
        while (mem_addr != 64'h63 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rmm_reach_b3", mem_addr, 64'h63);
        mem_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hA0;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("stall_addr_held", mem_addr, 64'h63);
        check("stall_req_held", mem_req, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        check("pend_restart_addr", mem_addr, 64'hA0);
        check("pend_no_valid", inst_valid, 0);
        wait_valid("opq");
        check("opq_icode", icode, 4'h6);
        check("opq_ifun", ifun, 4'h1);
        check("opq_rA", rA, 4'h2);
        check("opq_rB", rB, 4'h3);
        check("opq_valC", valC, 64'd0);
        check("opq_valP", valP, 64'hA2);
        check("opq_pc", pc, 64'hA0);
        accept();
        wait_valid("halt3");
        accept();

        // Invalid icode
        redirect(64'hC0);
        @(negedge clk);
        check("err_error", error, 1);
        check("err_halted", halted, 1);
        check("err_mem_req", mem_req, 0);
        for (int i = 0; i < 3; i++) begin
            check("err_no_valid", inst_valid, 0);
            @(negedge clk);
        end
        redirect(64'hE0);
        check("err_clr_error", error, 0);
        check("err_clr_halted", halted, 0);
        check("err_resume_req", mem_req, 1);
        check("err_resume_addr", mem_addr, 64'hE0);

        // Async reset during byte 5 of mrmovq
        k = 0;
        while (mem_addr != 64'hE5 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mrm_reach_b5", mem_addr, 64'hE5);
        rst = 1'b1;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_inst_valid", inst_valid, 0);
        check("arst_pc", pc, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_resume_req", mem_req, 1);
        check("arst_resume_addr", mem_addr, 64'h0);

`ifdef FETCH_STATS_EN
        begin
            int dv = 0;
            int st = 0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            inst_ready = 1'b1;
            redirect(64'h0B);
            k = 0;
            while (dv < 20 && k < 2000) begin
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                if ((mem_req && !mem_ready) || (inst_valid && !inst_ready)) st++;
                if (inst_valid && inst_ready) dv++;
                @(negedge clk);
                k++;
            end
            check("stat_insts", 64'(stat_insts), 64'd20);
            check("stat_stalls", 64'(stat_stalls), 64'(st));
            mem_ready  = 1'b1;
            inst_ready = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
